// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32 core datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, owns the shared memory
// port via req/ready, counts retired instructions and traps on illegal opcodes or
// memory timeouts.
//
// state  | meaning
// FETCH  | request instruction word at PC, load IR and bump PC on ready
// DECODE | classify IR, latch instruction class and ALU operation
// EXEC   | drive ALU operands/operation from the latched class
// MEM    | data access at ALU result address (load or store)
// WB     | write rd from ALU result or memory data, retire
// TRAP   | halted after illegal instruction or memory timeout, left only by rst
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             reg_we,
  output logic             b_sel,
  output logic             wb_sel,
  output logic [1:0]       alu_sel,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_ADD, C_SUB, C_OR, C_ADDI, C_LW, C_SW
  } cls_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d, dec_cls;
  logic [1:0]       alu_q, alu_d, dec_alu;
  logic [1:0]       err_q, err_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic pc_we_c, ir_we_c, mem_req_c, mem_sel_c, mem_we_c, reg_we_c, b_sel_c, wb_sel_c;
  logic [1:0] alu_sel_c;
  logic use_imm;

  // Instruction classification from opcode/funct3/funct7
  always_comb begin
    dec_cls = C_NONE;
    dec_alu = 2'b00;
    unique case (instr[6:0])
      7'b0110011: begin
        if (instr[14:12] == 3'b000 && instr[31:25] == 7'b0000000) dec_cls = C_ADD;
        else if (instr[14:12] == 3'b000 && instr[31:25] == 7'b0100000) begin
          dec_cls = C_SUB;
          dec_alu = 2'b01;
        end else if (instr[14:12] == 3'b110 && instr[31:25] == 7'b0000000) begin
          dec_cls = C_OR;
          dec_alu = 2'b10;
        end
      end
      7'b0010011: if (instr[14:12] == 3'b000) dec_cls = C_ADDI;
      7'b0000011: if (instr[14:12] == 3'b010) dec_cls = C_LW;
      7'b0100011: if (instr[14:12] == 3'b010) dec_cls = C_SW;
      default:    dec_cls = C_NONE;
    endcase
  end

  assign use_imm = (cls_q == C_ADDI) || (cls_q == C_LW) || (cls_q == C_SW);

  // Next-state, counters and datapath enables
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    alu_d     = alu_q;
    err_d     = err_q;
    wait_d    = '0;
    ret_d     = ret_q;
    pc_we_c   = 1'b0;
    ir_we_c   = 1'b0;
    mem_req_c = 1'b0;
    mem_sel_c = 1'b0;
    mem_we_c  = 1'b0;
    reg_we_c  = 1'b0;
    b_sel_c   = 1'b0;
    wb_sel_c  = 1'b0;
    alu_sel_c = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          err_d   = 2'b10;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        alu_d = dec_alu;
        if (dec_cls == C_NONE) begin
          state_d = S_TRAP;
          err_d   = 2'b01;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_sel_c = alu_q;
        b_sel_c   = use_imm;
        state_d   = (cls_q == C_LW || cls_q == C_SW) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_sel_c = 1'b1;
        mem_we_c  = (cls_q == C_SW);
        alu_sel_c = alu_q;
        b_sel_c   = use_imm;
        if (mem_ready) begin
          if (cls_q == C_SW) begin
            ret_d   = ret_q + CNT_W'(1);
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          err_d   = 2'b10;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        reg_we_c  = 1'b1;
        wb_sel_c  = (cls_q != C_LW);
        alu_sel_c = alu_q;
        b_sel_c   = use_imm;
        ret_d     = ret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // State and bookkeeping registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      alu_q   <= 2'b00;
      err_q   <= 2'b00;
      wait_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      alu_q   <= alu_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      ret_q   <= ret_d;
    end
  end

  // rst forces every output low immediately, aborting any in-flight access
  always_comb begin
    pc_we    = ~rst & pc_we_c;
    ir_we    = ~rst & ir_we_c;
    mem_req  = ~rst & mem_req_c;
    mem_sel  = ~rst & mem_sel_c;
    mem_we   = ~rst & mem_we_c;
    reg_we   = ~rst & reg_we_c;
    b_sel    = ~rst & b_sel_c;
    wb_sel   = ~rst & wb_sel_c;
    alu_sel  = rst ? 2'b00 : alu_sel_c;
    halted   = ~rst & (state_q == S_TRAP);
    err_code = rst ? 2'b00 : err_q;
    retired  = rst ? '0 : ret_q;
    state    = rst ? 3'd0 : state_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a transaction model expands each
// instruction (with chosen wait counts) into an expected per-cycle trace.
module tb_multicycle_ctrl;
  localparam int TO = 15;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst, mem_ready;
  logic [31:0] instr;
  logic pc_we, ir_we, mem_req, mem_sel, mem_we, reg_we, b_sel, wb_sel, halted;
  logic [1:0] alu_sel, err_code;
  logic [CW-1:0] retired;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .mem_req(mem_req), .mem_sel(mem_sel),
    .mem_we(mem_we), .reg_we(reg_we), .b_sel(b_sel), .wb_sel(wb_sel),
    .alu_sel(alu_sel), .halted(halted), .err_code(err_code),
    .retired(retired), .state(state)
  );

  typedef struct {
    bit [2:0] st;
    bit       rdy;
    bit       pc_we, ir_we, mem_req, mem_sel, mem_we, reg_we, wb_sel, b_sel, halted, chk_alu;
    bit [1:0] alu, err;
    int       ret;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int m_ret = 0;
  bit m_trap = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // -1 illegal, 0 add, 1 sub, 2 or, 3 addi, 4 lw, 5 sw
  function automatic int classify(input logic [31:0] i);
    logic [6:0] op = i[6:0];
    logic [2:0] f3 = i[14:12];
    logic [6:0] f7 = i[31:25];
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) return 0;
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) return 1;
    if (op == 7'h33 && f3 == 3'd6 && f7 == 7'h00) return 2;
    if (op == 7'h13 && f3 == 3'd0) return 3;
    if (op == 7'h03 && f3 == 3'd2) return 4;
    if (op == 7'h23 && f3 == 3'd2) return 5;
    return -1;
  endfunction

  function automatic logic [31:0] rnd_legal();
    logic [4:0] rd = 5'($urandom), rs1 = 5'($urandom), rs2 = 5'($urandom);
    logic [11:0] imm = 12'($urandom);
    case ($urandom % 6)
      0: return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
      1: return {7'h20, rs2, rs1, 3'b000, rd, 7'b0110011};
      2: return {7'h00, rs2, rs1, 3'b110, rd, 7'b0110011};
      3: return {imm, rs1, 3'b000, rd, 7'b0010011};
      4: return {imm, rs1, 3'b010, rd, 7'b0000011};
      default: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endcase
  endfunction

  function automatic exp_t mk(input int st);
    exp_t e;
    e = '{default: 0};
    e.st  = 3'(st);
    e.rdy = 1'($urandom);
    return e;
  endfunction

  task automatic push(input exp_t e);
    e.ret = m_ret % 16;
    q.push_back(e);
  endtask

  task automatic trap_tail(input bit [1:0] err);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e = mk(5);
      e.halted = 1'b1;
      e.err = err;
      push(e);
    end
    m_trap = 1'b1;
  endtask

  task automatic gen(input logic [31:0] ins, input int fw, input int mw);
    exp_t e;
    int c = classify(ins);
    bit [1:0] alu = (c == 1) ? 2'd1 : (c == 2) ? 2'd2 : 2'd0;
    bit imm = (c >= 3);
    for (int k = 0; k < fw && k < TO; k++) begin
      e = mk(0); e.rdy = 1'b0; e.mem_req = 1'b1; push(e);
    end
    if (fw >= TO) begin trap_tail(2'b10); return; end
    e = mk(0); e.rdy = 1'b1; e.mem_req = 1'b1; e.pc_we = 1'b1; e.ir_we = 1'b1; push(e);
    e = mk(1); push(e);
    if (c < 0) begin trap_tail(2'b01); return; end
    e = mk(2); e.chk_alu = 1'b1; e.alu = alu; e.b_sel = imm; push(e);
    if (c < 4) begin
      e = mk(4); e.reg_we = 1'b1; e.wb_sel = 1'b1; push(e);
      m_ret++;
      return;
    end
    for (int k = 0; k <= mw && k <= TO; k++) begin
      if (k == TO) begin trap_tail(2'b10); return; end
      e = mk(3); e.rdy = (k == mw); e.mem_req = 1'b1; e.mem_sel = 1'b1;
      e.mem_we = (c == 5); e.chk_alu = 1'b1; e.alu = alu; e.b_sel = imm;
      push(e);
    end
    if (c == 5) begin m_ret++; return; end
    e = mk(4); e.reg_we = 1'b1; e.wb_sel = 1'b0; push(e);
    m_ret++;
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'($urandom);
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_pc_we", 32'(pc_we), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_err", 32'(err_code), 0);
      chk("rst_retired", 32'(retired), 0);
    end
    m_ret = 0;
    m_trap = 1'b0;
  endtask

  task automatic run_q(input logic [31:0] ins);
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      rst = 1'b0;
      instr = ins;
      mem_ready = e.rdy;
      #1;
      chk("state", 32'(state), 32'(e.st));
      chk("pc_we", 32'(pc_we), 32'(e.pc_we));
      chk("ir_we", 32'(ir_we), 32'(e.ir_we));
      chk("mem_req", 32'(mem_req), 32'(e.mem_req));
      chk("mem_sel", 32'(mem_sel), 32'(e.mem_sel));
      chk("mem_we", 32'(mem_we), 32'(e.mem_we));
      chk("reg_we", 32'(reg_we), 32'(e.reg_we));
      chk("wb_sel", 32'(wb_sel), 32'(e.wb_sel));
      chk("halted", 32'(halted), 32'(e.halted));
      chk("err_code", 32'(err_code), 32'(e.err));
      chk("retired", 32'(retired), 32'(e.ret));
      if (e.chk_alu) begin
        chk("alu_sel", 32'(alu_sel), 32'(e.alu));
        chk("b_sel", 32'(b_sel), 32'(e.b_sel));
      end
    end
    if (m_trap) do_reset();
  endtask

  task automatic go(input logic [31:0] ins, input int fw, input int mw);
    gen(ins, fw, mw);
    run_q(ins);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    rst = 1'b1; instr = '0; mem_ready = 1'b0;
    do_reset();

    go(32'h002081B3, 0, 0);                  // add, zero wait
    go(32'h0000A283, 0, 3);                  // lw, 3 wait cycles in MEM
    go(32'h0050A023, 0, 0);                  // sw
    go(32'h40208233, 1, 0);                  // sub
    go(32'h0020E233, 2, 0);                  // or
    go(32'hFFFFFFFF, 0, 0);                  // illegal -> trap, reset
    go(32'h00108093, TO, 0);                 // fetch timeout -> trap, reset
    go(32'h00108093, TO - 1, 0);             // one short of timeout
    go(32'h0000A283, 0, TO - 1);             // lw one short of MEM timeout
    go(32'h0050A023, 0, TO);                 // sw MEM timeout -> trap, reset

    do_reset();
    for (int k = 0; k < 17; k++) go(32'h00108093, 0, 0);   // retired wraps 15 -> 0

    for (int k = 0; k < 60; k++) begin
      ins = ($urandom % 8 == 0) ? $urandom : rnd_legal();
      go(ins, ($urandom % 10 == 0) ? TO : int'($urandom % 4), int'($urandom % 4));
    end

    // rst asserted mid-MEM
    do_reset();
    gen(32'h0000A283, 0, 5);
    for (int k = 0; k < 5; k++) void'(q.pop_back());
    m_ret = 0;
    run_q(32'h0000A283);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("mid_mem_state", 32'(state), 3);
    chk("mid_mem_req", 32'(mem_req), 1);
    rst = 1'b1;
    #1;
    chk("rst_drop_req", 32'(mem_req), 0);
    chk("rst_drop_sel", 32'(mem_sel), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_state", 32'(state), 0);
    chk("post_rst_req", 32'(mem_req), 1);
    chk("post_rst_sel", 32'(mem_sel), 0);
    chk("post_rst_retired", 32'(retired), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
